// File: rtl/hub75_rx.sv
// HUB75 panel-side receiver: resynchronises the scan bus, rebuilds each latched
// row and streams it into a frame-buffer write port while measuring on-time.
module hub75_rx #(
  parameter int unsigned COLS        = 64,
  parameter int unsigned ROW_W       = 5,
  parameter int unsigned PLANE_W     = 3,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hub_clk,
  input  logic                    hub_lat,
  input  logic                    hub_noe,
  input  logic [ROW_W-1:0]        hub_row,
  input  logic [2:0]              hub_rgb0,
  input  logic [2:0]              hub_rgb1,
  input  logic                    clr_status,
  output logic                    wr_en,
  output logic [ROW_W-1:0]        wr_row,
  output logic [$clog2(COLS)-1:0] wr_col,
  output logic [PLANE_W-1:0]      wr_plane,
  output logic [5:0]              wr_data,
  output logic [CNT_W-1:0]        on_cycles,
  output logic                    on_valid,
  output logic                    frame_done,
  output logic                    len_err,
  output logic                    overrun
);

  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned CC_W  = $clog2(COLS + 1);
  localparam int unsigned SW    = ROW_W + 9;
  localparam int unsigned LAST  = SYNC_STAGES - 1;
  localparam logic [CC_W-1:0]  COLS_C   = CC_W'(COLS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  // Bus vector {clk, lat, noe, row, rgb1, rgb0}; noe idles high (panel dark).
  localparam logic [SW-1:0]    SYNC_RST = {3'b001, {(ROW_W + 6){1'b0}}};

  typedef enum logic {IDLE, WRITE} state_t;

  logic [SW-1:0] sync_q [SYNC_STAGES];
  logic [SW-1:0] dly_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
      dly_q <= SYNC_RST;
    end else begin
      sync_q[0] <= {hub_clk, hub_lat, hub_noe, hub_row, hub_rgb1, hub_rgb0};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      dly_q <= sync_q[LAST];
    end
  end

  logic             clk_rise, lat_rise, noe_low;
  logic [ROW_W-1:0] row_s;
  logic [5:0]       pix_s;

  assign clk_rise = sync_q[LAST][SW-1] & ~dly_q[SW-1];
  assign lat_rise = sync_q[LAST][SW-2] & ~dly_q[SW-2];
  assign noe_low  = ~dly_q[SW-3];
  assign row_s    = dly_q[ROW_W+5:6];
  assign pix_s    = dly_q[5:0];

  state_t             state_q;
  logic [5:0]         shift_buf_q [COLS];
  logic [5:0]         hold_buf_q  [COLS];
  logic [CC_W-1:0]    col_cnt_q;
  logic               extra_q;
  logic [ROW_W-1:0]   last_row_q;
  logic [PLANE_W-1:0] plane_q;
  logic [CNT_W-1:0]   on_cnt_q;
  logic               wr_en_q, on_valid_q, frame_done_q, len_err_q, overrun_q;
  logic [ROW_W-1:0]   wr_row_q;
  logic [COL_W-1:0]   wr_col_q;
  logic [PLANE_W-1:0] wr_plane_q;
  logic [5:0]         wr_data_q;
  logic [CNT_W-1:0]   on_cycles_q;

  // Same-cycle shift is folded in before the latch looks at the row.
  logic               shift_ok;
  logic [5:0]         shift_buf_d [COLS];
  logic [CC_W-1:0]    col_cnt_d;
  logic               extra_d;
  logic               bad_len;
  logic [PLANE_W-1:0] plane_d;

  always_comb begin
    shift_buf_d = shift_buf_q;
    shift_ok    = clk_rise && (col_cnt_q < COLS_C);
    col_cnt_d   = col_cnt_q;
    if (shift_ok) begin
      shift_buf_d[col_cnt_q[COL_W-1:0]] = pix_s;
      col_cnt_d = col_cnt_q + CC_W'(1);
    end
    extra_d = extra_q | (clk_rise & ~shift_ok);
    bad_len = (col_cnt_d != COLS_C) | extra_d;
    plane_d = (row_s == last_row_q) ? plane_q + PLANE_W'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      for (int unsigned i = 0; i < COLS; i++) begin
        shift_buf_q[i] <= '0;
        hold_buf_q[i]  <= '0;
      end
      col_cnt_q    <= '0;
      extra_q      <= 1'b0;
      last_row_q   <= '1;
      plane_q      <= '0;
      on_cnt_q     <= '0;
      wr_en_q      <= 1'b0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      wr_plane_q   <= '0;
      wr_data_q    <= '0;
      on_cycles_q  <= '0;
      on_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      len_err_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      shift_buf_q  <= shift_buf_d;
      on_valid_q   <= lat_rise;
      frame_done_q <= 1'b0;
      len_err_q    <= (lat_rise & bad_len) | (len_err_q & ~clr_status);
      overrun_q    <= (lat_rise & (state_q == WRITE)) | (overrun_q & ~clr_status);

      if (lat_rise) begin
        col_cnt_q   <= '0;
        extra_q     <= 1'b0;
        on_cycles_q <= on_cnt_q;
        on_cnt_q    <= noe_low ? CNT_W'(1) : '0;
      end else begin
        col_cnt_q <= col_cnt_d;
        extra_q   <= extra_d;
        if (noe_low && (on_cnt_q != '1)) on_cnt_q <= on_cnt_q + CNT_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (lat_rise) begin
            hold_buf_q   <= shift_buf_d;
            plane_q      <= plane_d;
            last_row_q   <= row_s;
            frame_done_q <= (row_s == '0) && (last_row_q != '0);
            wr_en_q      <= 1'b1;
            wr_row_q     <= row_s;
            wr_col_q     <= '0;
            wr_plane_q   <= plane_d;
            wr_data_q    <= shift_buf_d[0];
            state_q      <= WRITE;
          end
        end
        WRITE: begin
          if (wr_col_q == LAST_COL) begin
            wr_en_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            wr_col_q  <= wr_col_q + COL_W'(1);
            wr_data_q <= hold_buf_q[wr_col_q + COL_W'(1)];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_row     = wr_row_q;
  assign wr_col     = wr_col_q;
  assign wr_plane   = wr_plane_q;
  assign wr_data    = wr_data_q;
  assign on_cycles  = on_cycles_q;
  assign on_valid   = on_valid_q;
  assign frame_done = frame_done_q;
  assign len_err    = len_err_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/hub75_rx.md
Name: hub75_rx

Overview:
- Panel-side receiver for the HUB75 scan interface that our panel controller drives. It samples the panel clock, latch, output-enable, row address and dual RGB data lines. It rebuilds each latched row and streams it into a frame-buffer write port.
- It also measures on-time and row length. It serves both as the loopback checker for the panel driver and as the front end of a panel emulator.

Parameters:
COLS, 64, shifted pixels per row (panel width).
ROW_W, 5, row address width (2^ROW_W scan rows).
PLANE_W, 3, bit-plane index width.
CNT_W, 16, on-time counter width.
SYNC_STAGES, 2, synchronizer depth on all hub_* inputs (minimum 2).

Ports:
clk  in  1  system clock, at least 4x the panel clock rate.
rst  in  1  asynchronous, active-low reset.
hub_clk  in  1  panel shift clock; data is captured on its rising edge.
hub_lat  in  1  panel latch; its rising edge commits a row.
hub_noe  in  1  panel output enable, active-low.
hub_row  in  ROW_W  row address.
hub_rgb0  in  3  upper-half {R,G,B}.
hub_rgb1  in  3  lower-half {R,G,B}.
clr_status  in  1  synchronous clear of the sticky flags.
wr_en  out  1  frame-buffer write strobe.
wr_row  out  ROW_W  write row.
wr_col  out  $clog2(COLS)  write column.
wr_plane  out  PLANE_W  write bit plane.
wr_data  out  6  {rgb1,rgb0} of the pixel.
on_cycles  out  CNT_W  clk cycles with hub_noe low during the previous latch interval.
on_valid  out  1  one-cycle pulse when on_cycles updates.
frame_done  out  1  one-cycle pulse at a row-address wrap.
len_err  out  1  sticky: a committed row had a shift count other than COLS.
overrun  out  1  sticky: a latch arrived while a write-out was in progress.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs 0, all counters 0, FSM in IDLE.
  - last_row = all ones; plane = 0.
- Synchronization:
  - Every hub_* input passes through SYNC_STAGES flops.
  - Edge detection compares the last synchronized stage with one extra delay flop.
  - Data and row are sampled from that same delayed stage, so they stay aligned with the clock and latch edges.
- Shift:
  - On each hub_clk rising edge with col_cnt < COLS: shift_buf[col_cnt] <= {rgb1,rgb0}, then col_cnt+1.
  - At COLS, col_cnt saturates, further data is dropped, and an extra flag is set.
- Latch commit (hub_lat rising edge):
  - If a hub_clk edge falls in the same cycle, the shift is applied first and that pixel is included.
  - len_err sets if (col_cnt + same-cycle shift) != COLS or the extra flag is set.
  - col_cnt and the extra flag clear.
  - If the FSM is IDLE:
    - Copy shift_buf to hold_buf and capture row.
    - Plane: plane+1 (wraps at 2^PLANE_W) when row == last_row; otherwise 0.
    - last_row <= row.
    - frame_done pulses if row == 0 and the previous last_row != 0.
    - FSM goes to WRITE.
  - If the FSM is WRITE: overrun sets, hold_buf/plane/last_row are untouched, and the latch is dropped.
- FSM:
  - IDLE -> WRITE on an accepted latch.
  - WRITE: wr_en = 1 for exactly COLS consecutive cycles, starting the cycle after latch detection.
  - wr_col runs 0..COLS-1 with wr_data = hold_buf[wr_col]; wr_row and wr_plane are constant over the burst.
  - After the cycle with wr_col == COLS-1, the FSM returns to IDLE.
- On-time:
  - on_cnt increments every cycle synced noe is low, saturating at 2^CNT_W-1.
  - On every latch edge, accepted or dropped: on_cycles <= on_cnt, on_valid pulses the next cycle, on_cnt <= 0.
  - If noe is low in the latch cycle, that cycle is counted into the new interval.
- Sticky flags: clr_status clears them. A set event in the same cycle wins over clr_status.
- Reset mid-burst: wr_en drops immediately and no partial-row resumption occurs.

Test Plan:
1. COLS=8: shift 8 pixels 0x01..0x08 on row 3, then latch -> after sync latency plus 1, wr_en for 8 cycles, wr_col 0..7, wr_data 0x01..0x08, wr_row=3, wr_plane=0, len_err=0.
2. Three latches on row 3, then one on row 4 (8 shifts each, spaced wider than the burst) -> wr_plane 0,1,2 then 0.
3. 7 shifts and then 9 shifts, each followed by a latch -> len_err set after the first and stays set; clr_status clears it.
4. Second latch 3 cycles into a burst -> overrun=1, burst data unchanged, only one burst issued; on_valid still pulses for both latches.
5. hub_noe low for 40 clk cycles between latches -> on_cycles=40 with one on_valid pulse. Same-cycle hub_clk and hub_lat edges -> that pixel lands in column 7.
6. Rows 30, 31, 0 latched -> frame_done pulses once, on the row-0 commit. Assert rst mid-burst -> wr_en=0 immediately, all outputs 0.
